// File: rtl/mu0_boot_memory.sv
// MU0 program/data memory with a streaming boot loader.
// Clears the array, loads an image, holds the core in reset, then serves the CPU bus.
module mu0_boot_memory #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 32,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic              memrq,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic [ADDR_W:0]   load_cnt,
    output logic              addr_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [7:0]      HOLD_L   = 8'(RST_HOLD);

    logic [1:0]        state;
    logic [AW-1:0]     clr_ptr;
    logic [7:0]        hold_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ld_fire;
    logic              ld_end;
    logic              cpu_req;
    logic              in_rng;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] wd;

    assign ld_ready  = (state == S_LOAD);
    assign cpu_rst_n = (state == S_RUN);
    assign boot_done = (state == S_RUN);

    assign ld_fire = ld_ready & ld_valid;
    assign ld_end  = ld_fire & (ld_last | (load_cnt == DEPTH_L - 1'b1));
    assign cpu_req = (state == S_RUN) & memrq;
    assign in_rng  = ({1'b0, address} < DEPTH_L);

    // Single write port shared by clear, loader and CPU; states make them exclusive.
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        unique case (1'b1)
            (state == S_CLEAR): begin
                we = 1'b1;
                wa = clr_ptr;
            end
            ld_fire: begin
                we = 1'b1;
                wa = load_cnt[AW-1:0];
                wd = ld_data;
            end
            (cpu_req & ~rnw & in_rng): begin
                we = 1'b1;
                wa = address[AW-1:0];
                wd = in_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            clr_ptr  <= '0;
            hold_cnt <= '0;
            load_cnt <= '0;
            addr_err <= 1'b0;
            out_data <= '0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_IDX) begin
                        clr_ptr <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ld_fire) load_cnt <= load_cnt + 1'b1;
                    if (ld_end) begin
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_L) state <= S_RUN;
                    else hold_cnt <= hold_cnt + 1'b1;
                end
                S_RUN: begin
                    if (memrq) begin
                        if (rnw) out_data <= in_rng ? mem[address[AW-1:0]] : '0;
                        if (!in_rng) addr_err <= 1'b1;
                    end
                    // The access above still happens; reload only restarts the boot.
                    if (reload) begin
                        state    <= S_CLEAR;
                        clr_ptr  <= '0;
                        load_cnt <= '0;
                        addr_err <= 1'b0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_boot_memory.sv
// Directed bench for mu0_boot_memory with a small MU0 instruction model.
module tb_mu0_boot_memory;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 32;
    localparam int RST_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              reload = 1'b0;
    logic              memrq = 1'b0;
    logic              rnw = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              cpu_rst_n;
    logic              boot_done;
    logic [ADDR_W:0]   load_cnt;
    logic              addr_err;

    int checks = 0;
    int failures = 0;

    mu0_boot_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last),
        .reload(reload), .memrq(memrq), .rnw(rnw),
        .address(address), .in_data(in_data), .out_data(out_data),
        .cpu_rst_n(cpu_rst_n), .boot_done(boot_done),
        .load_cnt(load_cnt), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (!ld_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_ready", 32'(ld_ready), 1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic cpu_read(input logic [11:0] a, output logic [15:0] d);
        memrq   = 1'b1;
        rnw     = 1'b1;
        address = a;
        tick();
        d = out_data;
        memrq = 1'b0;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        memrq   = 1'b1;
        rnw     = 1'b0;
        address = a;
        in_data = d;
        tick();
        memrq = 1'b0;
        rnw   = 1'b1;
    endtask

    task automatic run_mu0(output logic [15:0] acc_o, output logic halted);
        logic [11:0] pc;
        logic [15:0] acc, ir, v;
        pc = '0;
        acc = '0;
        halted = 1'b0;
        for (int i = 0; i < 2000 && !halted; i++) begin
            cpu_read(pc, ir);
            pc = pc + 1'b1;
            case (ir[15:12])
                4'h0: cpu_read(ir[11:0], acc);
                4'h1: cpu_write(ir[11:0], acc);
                4'h2: begin cpu_read(ir[11:0], v); acc = acc + v; end
                4'h3: begin cpu_read(ir[11:0], v); acc = acc - v; end
                4'h4: pc = ir[11:0];
                4'h5: if (!acc[15]) pc = ir[11:0];
                4'h6: if (acc != 0) pc = ir[11:0];
                default: halted = 1'b1;
            endcase
        end
        acc_o = acc;
    endtask

    logic [15:0] prog [21];
    logic [15:0] d, acc;
    logic        halted;

    initial begin
        prog = '{16'h0013, 16'h1012, 16'h1011, 16'h0011, 16'h2014,
                 16'h1011, 16'h2012, 16'h1012, 16'h0011, 16'h3010,
                 16'h6003, 16'h7000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0012, 16'h0055, 16'h0077, 16'h0000,
                 16'h0001};

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("rst_boot_done", 32'(boot_done), 0);
        check("rst_load_cnt", 32'(load_cnt), 0);
        check("rst_addr_err", 32'(addr_err), 0);
        check("rst_out_data", 32'(out_data), 0);

        rst_n = 1'b1;
        repeat (DEPTH - 1) tick();
        check("boot_lat_pre", 32'(ld_ready), 0);
        tick();
        check("boot_lat", 32'(ld_ready), 1);
        check("boot_load_cnt", 32'(load_cnt), 0);

        for (int i = 0; i < 21; i++) push(prog[i], i == 20);
        check("prog_load_cnt", 32'(load_cnt), 21);
        check("prog_ready_low", 32'(ld_ready), 0);
        repeat (RST_HOLD) tick();
        check("release_pre", 32'(cpu_rst_n), 0);
        tick();
        check("release", 32'(cpu_rst_n), 1);
        check("boot_done", 32'(boot_done), 1);

        run_mu0(acc, halted);
        check("sum_halted", 32'(halted), 1);
        cpu_read(12'd18, d);
        check("sum_mem18", 32'(d), 171);
        cpu_read(12'd17, d);
        check("sum_mem17", 32'(d), 18);
        check("sum_addr_err", 32'(addr_err), 0);

        cpu_write(12'd5, 16'hA5A5);
        cpu_read(12'd5, d);
        check("wr_rd_5", 32'(d), 32'hA5A5);
        tick();
        check("rd_hold", 32'(out_data), 32'hA5A5);
        cpu_read(12'd40, d);
        check("oob_read", 32'(d), 0);
        check("oob_err", 32'(addr_err), 1);

        reload  = 1'b1;
        memrq   = 1'b1;
        rnw     = 1'b0;
        address = 12'd6;
        in_data = 16'h5555;
        tick();
        reload = 1'b0;
        memrq  = 1'b0;
        rnw    = 1'b1;
        check("reload_cpu_rst", 32'(cpu_rst_n), 0);
        check("reload_done", 32'(boot_done), 0);
        check("reload_err", 32'(addr_err), 0);
        check("reload_cnt", 32'(load_cnt), 0);
        repeat (DEPTH - 1) tick();
        check("reload_clear", 32'(ld_ready), 0);
        tick();
        check("reload_load", 32'(ld_ready), 1);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_ignored", 32'(ld_ready), 1);

        push(16'h0002, 1'b0);
        push(16'h7000, 1'b0);
        push(16'h1234, 1'b1);
        check("img2_cnt", 32'(load_cnt), 3);
        repeat (RST_HOLD + 1) tick();
        check("img2_release", 32'(cpu_rst_n), 1);
        run_mu0(acc, halted);
        check("img2_halted", 32'(halted), 1);
        check("img2_acc", 32'(acc), 32'h1234);
        cpu_read(12'd10, d);
        check("img2_clear10", 32'(d), 0);
        cpu_read(12'd5, d);
        check("img2_clear5", 32'(d), 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (DEPTH) tick();
        for (int i = 0; i < 7; i++) push(16'h0F00 + 16'(i), 1'b0);
        check("part_cnt", 32'(load_cnt), 7);
        rst_n = 1'b0;
        #1;
        check("abort_cnt", 32'(load_cnt), 0);
        check("abort_ready", 32'(ld_ready), 0);
        check("abort_cpu_rst", 32'(cpu_rst_n), 0);
        check("abort_out", 32'(out_data), 0);
        tick();
        rst_n = 1'b1;
        repeat (DEPTH - 1) tick();
        check("abort_clear", 32'(ld_ready), 0);
        tick();
        check("abort_load", 32'(ld_ready), 1);
        check("abort_load_cnt", 32'(load_cnt), 0);

        for (int i = 0; i < DEPTH; i++) push(16'h0100 + 16'(i), 1'b0);
        check("full_ready_low", 32'(ld_ready), 0);
        check("full_cnt", 32'(load_cnt), 32);
        ld_valid = 1'b1;
        ld_data  = 16'hDEAD;
        memrq    = 1'b1;
        rnw      = 1'b0;
        address  = 12'd0;
        in_data  = 16'hFFFF;
        tick();
        ld_valid = 1'b0;
        memrq    = 1'b0;
        rnw      = 1'b1;
        check("full_extra", 32'(load_cnt), 32);
        repeat (RST_HOLD) tick();
        check("full_release", 32'(cpu_rst_n), 1);
        cpu_read(12'd0, d);
        check("full_mem0", 32'(d), 32'h0100);
        cpu_read(12'd31, d);
        check("full_mem31", 32'(d), 32'h011F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
